data_mem_arbiter: RTL

- Shares the single-port data memory (DATA_MEM_DEPTH words) between the main core and SUBCORE_NUM subcores.
- Requester 0 is the main core; requesters 1..SUBCORE_NUM are the subcores.
- Grants one access per cycle, round-robin, and drives the BRAM port.
- Returns read data to the owning requester after the fixed memory latency, tagged by a requester-ID pipeline. Out-of-range addresses are trapped.

---
 rtl/data_mem_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Shares one single-port data memory between N_REQ requesters (index 0 is the
// main core, 1..N_REQ-1 are subcores). One access is granted per cycle using a
// round-robin scan that starts at rr_ptr_q. The winner drives the BRAM port in
// the same cycle as its grant. Reads are tracked by a MEM_LATENCY-deep
// {valid, id, oor} pipeline so that the memory output can be steered back to
// the owning requester once it arrives. Accesses beyond DEPTH are still
// granted and consumed, but they never reach the memory. They also set a
// sticky per-requester error flag, and reads of this kind return zero.
//
// Ports
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   req_i       per-requester request, payload held stable until granted
//   addr_i      per-requester word address, slice i = [i*32 +: 32]
//   din_i       per-requester write data, slice i = [i*32 +: 32]
//   we_i        per-requester byte write enables, slice i = [i*4 +: 4], 0 = read
//   gnt_o       one-hot combinational grant
//   rvalid_o    one-cycle read-data-valid pulse for the owning requester
//   rdata_o     shared read data bus, qualified by rvalid_o
//   addr_err_o  sticky out-of-range flag per requester
//   mem_en_o    memory enable
//   mem_addr_o  memory word address
//   mem_din_o   memory write data
//   mem_we_o    memory byte write enables
//   mem_dout_i  memory read data, valid MEM_LATENCY cycles after mem_en_o

module data_mem_arbiter #(
  parameter int unsigned N_REQ       = 5,
  parameter int unsigned DEPTH       = 120000,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ*32-1:0] addr_i,
  input  logic [N_REQ*32-1:0] din_i,
  input  logic [N_REQ*4-1:0]  we_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    rvalid_o,
  output logic [31:0]         rdata_o,
  output logic [N_REQ-1:0]    addr_err_o,
  output logic                mem_en_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [31:0]         mem_din_o,
  output logic [3:0]          mem_we_o,
  input  logic [31:0]         mem_dout_i
);

  localparam int unsigned IdW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Round-robin pointer: index scanned first in the current cycle.
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

  // Arbitration results.
  logic           win_found;
  logic [IdW-1:0] win_id;
  logic           grant_valid;
  int unsigned    scan_idx;

  // Payload of the winning requester.
  logic [31:0]    addr_w;
  logic [31:0]    din_w;
  logic [3:0]     we_w;
  logic           oor_w;
  logic           is_read_w;

  // Read return pipeline; stage 0 is loaded at the grant edge.
  logic [MEM_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [MEM_LATENCY-1:0] pipe_oor_q, pipe_oor_d;
  logic [IdW-1:0]         pipe_id_q [MEM_LATENCY];
  logic [IdW-1:0]         pipe_id_d [MEM_LATENCY];

  logic           tail_valid;
  logic           tail_oor;
  logic [IdW-1:0] tail_id;

  logic [N_REQ-1:0] addr_err_q, addr_err_d;

  // --------------------------------------------------------------------------
  // Arbitration: scan ascending from rr_ptr_q with wrap, first request wins.
  // --------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(rr_ptr_q) + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!win_found && req_i[scan_idx[IdW-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[IdW-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held, even though the scan is comb.
  assign grant_valid = rst_ni & win_found;

  always_comb begin
    gnt_o = '0;
    if (grant_valid) begin
      gnt_o[win_id] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Winner payload mux and memory drive.
  // --------------------------------------------------------------------------
  always_comb begin
    addr_w = '0;
    din_w  = '0;
    we_w   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_id == IdW'(i)) begin
        addr_w = addr_i[i*32 +: 32];
        din_w  = din_i[i*32 +: 32];
        we_w   = we_i[i*4 +: 4];
      end
    end
  end

  assign oor_w     = (addr_w >= DEPTH);
  assign is_read_w = (we_w == 4'b0000);

  assign mem_en_o   = grant_valid & ~oor_w;
  assign mem_addr_o = addr_w[ADDR_W-1:0];
  assign mem_din_o  = din_w;
  assign mem_we_o   = mem_en_o ? we_w : 4'b0000;

  // --------------------------------------------------------------------------
  // Pointer advance: the requester after the winner is scanned first next.
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (win_id == IdW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read return pipeline and sticky error flags.
  // --------------------------------------------------------------------------
  always_comb begin
    // Writes enter the pipeline as bubbles so they never produce rvalid.
    pipe_valid_d[0] = grant_valid & is_read_w;
    pipe_oor_d[0]   = oor_w;
    pipe_id_d[0]    = win_id;
    for (int unsigned s = 1; s < MEM_LATENCY; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_oor_d[s]   = pipe_oor_q[s-1];
      pipe_id_d[s]    = pipe_id_q[s-1];
    end
  end

  always_comb begin
    addr_err_d = addr_err_q;
    if (oor_w) begin
      addr_err_d = addr_err_q | gnt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      pipe_valid_q <= '0;
      pipe_oor_q   <= '0;
      for (int unsigned s = 0; s < MEM_LATENCY; s++) begin
        pipe_id_q[s] <= '0;
      end
      addr_err_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_oor_q   <= pipe_oor_d;
      pipe_id_q    <= pipe_id_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response: the tail stage lines up with mem_dout_i, so rvalid comes
  // straight from the tail flops and rdata is the memory output steered
  // through. Trapped reads return zero instead of whatever the memory shows.
  // --------------------------------------------------------------------------
  assign tail_valid = pipe_valid_q[MEM_LATENCY-1];
  assign tail_oor   = pipe_oor_q[MEM_LATENCY-1];
  assign tail_id    = pipe_id_q[MEM_LATENCY-1];

  always_comb begin
    rvalid_o = '0;
    if (tail_valid) begin
      rvalid_o[tail_id] = 1'b1;
    end
  end

  assign rdata_o    = (tail_valid && !tail_oor) ? mem_dout_i : 32'h0000_0000;
  assign addr_err_o = addr_err_q;

endmodule
